// File: rtl/wb_mem_slave.sv
// wb_mem_slave: pipelined Wishbone B4 responder backed by a single-port
// word memory. Requests are accepted one per cycle, writes commit with byte
// enables at the accept edge, and responses (ack or err) come back strictly
// in order after a fixed LATENCY. wb_stall_o throttles the initiator once
// MAX_OUTSTANDING requests are accepted but not yet answered.
//
// Handshake: a request transfers at a rising edge where
// wb_cyc_i & wb_stb_i & ~wb_stall_o; stall depends on registered state only,
// and acks cannot be back-pressured. Dropping wb_cyc_i aborts everything in
// flight (committed writes stay in memory).
module wb_mem_slave #(
    parameter int CORE_ADDR_WIDTH = 32,
    parameter int CORE_DATA_WIDTH = 32,
    parameter int CORE_BE_WIDTH   = CORE_DATA_WIDTH / 8,
    parameter int MEM_WORDS       = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [CORE_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [CORE_BE_WIDTH-1:0]   wb_sel_i,
    input  logic [CORE_DATA_WIDTH-1:0] wb_dat_i,
    output logic [CORE_DATA_WIDTH-1:0] wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic                       wb_stall_o
);

    localparam int BE_LG = $clog2(CORE_BE_WIDTH);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CORE_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Response pipeline: stage 0 is loaded at the accept edge, stage
    // LATENCY-1 drives the bus outputs.
    logic [LATENCY-1:0]         pv;
    logic [LATENCY-1:0]         pe;
    logic [LATENCY-1:0]         pw;
    logic [CORE_DATA_WIDTH-1:0] pd [LATENCY];

    logic [CNT_W-1:0] out_cnt;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             accept;
    logic             resp;
    logic             unused_adr_lsb;

    assign idx            = wb_adr_i[BE_LG +: IDX_W];
    assign unused_adr_lsb = ^wb_adr_i[BE_LG-1:0];

    // Any address bit above the word index means the access is out of range.
    generate
        if (BE_LG + IDX_W < CORE_ADDR_WIDTH) begin : g_range_hi
            assign in_range = ~|wb_adr_i[CORE_ADDR_WIDTH-1:BE_LG+IDX_W];
        end else begin : g_range_full
            assign in_range = 1'b1;
        end
    endgenerate

    assign wb_stall_o = (out_cnt == CNT_W'(MAX_OUTSTANDING));
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign resp       = pv[LATENCY-1];

    assign wb_ack_o = resp & ~pe[LATENCY-1];
    assign wb_err_o = resp &  pe[LATENCY-1];
    assign wb_dat_o = (resp & ~pe[LATENCY-1] & ~pw[LATENCY-1]) ? pd[LATENCY-1] : '0;

    // Byte-enabled write commit at the accept edge; memory is never reset.
    always_ff @(posedge wb_clk_i) begin
        if (accept && wb_we_i && in_range) begin
            for (int b = 0; b < CORE_BE_WIDTH; b++) begin
                if (wb_sel_i[b]) begin
                    mem[idx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
                end
            end
        end
    end

    // Load the response pipeline on accept, shift it every cycle, and clear
    // all valid bits when the initiator drops the bus cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pv <= '0;
            pe <= '0;
            pw <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            pe[0] <= ~in_range;
            pw[0] <= wb_we_i;
            pd[0] <= mem[idx];
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pw[i] <= pw[i-1];
                pd[i] <= pd[i-1];
            end
            if (!wb_cyc_i) begin
                pv <= '0;
            end
        end
    end

    // Track accepted-but-unanswered requests; an accept and a response in the
    // same cycle cancel out, and an abort empties the count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_cnt <= '0;
        end else if (!wb_cyc_i) begin
            out_cnt <= '0;
        end else if (accept && !resp) begin
            out_cnt <= out_cnt + 1'b1;
        end else if (!accept && resp) begin
            out_cnt <= out_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave. Two instances share the request bus:
// dut_a uses default parameters, dut_b uses LATENCY=4 / MAX_OUTSTANDING=2.
// Only the selected instance sees wb_cyc_i high. Every accepted request
// pushes {err, due cycle, data} into exp_q; a negedge monitor pops on each
// ack/err and also checks stall against the outstanding count.
module tb_wb_mem_slave;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic        use_b;

  logic [31:0] dat_a, dat_b, dat;
  logic        ack_a, ack_b, ack;
  logic        err_a, err_b, err;
  logic        stall_a, stall_b, stall;
  logic        cyc_a, cyc_b;

  int          total;
  int          bad;
  int          lat;
  int          mo;
  logic [31:0] cyc_cnt;
  logic [64:0] exp_q[$];

  assign cyc_a = cyc & ~use_b;
  assign cyc_b = cyc & use_b;
  assign ack   = use_b ? ack_b   : ack_a;
  assign err   = use_b ? err_b   : err_a;
  assign stall = use_b ? stall_b : stall_a;
  assign dat   = use_b ? dat_b   : dat_a;

  wb_mem_slave dut_a (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_cyc_i  (cyc_a),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_sel_i  (sel),
    .wb_dat_i  (dat_w),
    .wb_dat_o  (dat_a),
    .wb_ack_o  (ack_a),
    .wb_err_o  (err_a),
    .wb_stall_o(stall_a)
  );

  wb_mem_slave #(.LATENCY(4), .MAX_OUTSTANDING(2)) dut_b (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_cyc_i  (cyc_b),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_sel_i  (sel),
    .wb_dat_i  (dat_w),
    .wb_dat_o  (dat_b),
    .wb_ack_o  (ack_b),
    .wb_err_o  (err_b),
    .wb_stall_o(stall_b)
  );

  // clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = '0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one request and hold it until it is accepted (bounded wait).
  // Called and returns at #1 after a rising edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic e_err, input logic [31:0] e_dat);
    logic        st;
    logic [31:0] snap;
    bit          done;
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = w;
    adr   = a;
    sel   = s;
    dat_w = d;
    done  = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      st   = stall;
      snap = cyc_cnt;
      @(posedge clk);
      #1;
      if (!st) begin
        exp_q.push_back({e_err, snap + 32'(lat), e_dat});
        done = 1'b1;
      end
    end
    total++;
    assert (done) else begin
      bad++;
      $error("FAIL accept_timeout observed=stalled expected=accepted adr=%0h", a);
    end
  endtask

  // Stop requesting and wait (bounded) for all expected responses.
  task automatic drain(input string tag);
    int t;
    stb = 1'b0;
    t   = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitor: stall model plus in-order response checks
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst) begin
      total++;
      assert (stall === ((exp_q.size() == mo) ? 1'b1 : 1'b0)) else begin
        bad++;
        $error("FAIL stall observed=%b expected=%b cycle=%0d", stall,
               (exp_q.size() == mo), cyc_cnt);
      end
      if (ack || err) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_resp observed ack=%b err=%b expected=none cycle=%0d",
                 ack, err, cyc_cnt);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++;
          assert ({err, ack} === {e[64], ~e[64]}) else begin
            bad++;
            $error("FAIL resp_kind observed err/ack=%b%b expected err=%b cycle=%0d",
                   err, ack, e[64], cyc_cnt);
          end
          total++;
          assert (dat === e[31:0]) else begin
            bad++;
            $error("FAIL resp_data observed=%0h expected=%0h cycle=%0d", dat, e[31:0], cyc_cnt);
          end
          total++;
          assert (cyc_cnt === e[63:32]) else begin
            bad++;
            $error("FAIL resp_cycle observed=%0d expected=%0d", cyc_cnt, e[63:32]);
          end
        end
      end
    end
  end

  // directed stimulus
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    adr   = '0;
    sel   = '0;
    dat_w = '0;
    use_b = 1'b0;
    lat   = 2;
    mo    = 4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_stall", 32'(stall_a), 32'd0);
    chk("rst_dat", dat_a, 32'd0);
    chk("rst_cnt", 32'(dut_a.out_cnt), 32'd0);
    rst = 1'b0;
    cyc = 1'b1;
    @(posedge clk);
    #1;

    // preload, then a 4-beat read burst
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i), 1'b0, 32'h0);
    end
    drain("preload_drain");
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0, 1'b0, 32'hA0 + 32'(i));
    end
    drain("burst_drain");

    // byte-enable merge and sel=0 write
    issue(1'b1, 32'h40, 4'hF, 32'h11223344, 1'b0, 32'h0);
    issue(1'b1, 32'h40, 4'b0101, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h11AD33EF);
    issue(1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0);
    issue(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h11AD33EF);
    drain("be_drain");

    // out-of-range read and write; aliased word must stay intact
    issue(1'b1, 32'h8, 4'hF, 32'h55667788, 1'b0, 32'h0);
    issue(1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 32'h1008, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue(1'b0, 32'h8, 4'h0, 32'h0, 1'b0, 32'h55667788);
    drain("oor_drain");

    // abort: drop cyc after 3 accepts of a burst
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0, 1'b0, 32'hA0 + 32'(i));
    end
    cyc = 1'b0;
    stb = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("abort_cnt", 32'(dut_a.out_cnt), 32'd0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    cyc = 1'b1;
    issue(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h11AD33EF);
    drain("post_abort_drain");

    // switch to LATENCY=4 / MAX_OUTSTANDING=2 instance
    use_b = 1'b1;
    lat   = 4;
    mo    = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 32'h200 + 32'(4 * i), 4'hF, 32'hB0 + 32'(i), 1'b0, 32'h0);
    end
    drain("b_preload_drain");
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 32'h200 + 32'(4 * i), 4'h0, 32'h0, 1'b0, 32'hB0 + 32'(i));
    end
    drain("b_read_drain");
    chk("b_cnt_idle", 32'(dut_b.out_cnt), 32'd0);

    // asynchronous reset with responses in flight
    issue(1'b0, 32'h200, 4'h0, 32'h0, 1'b0, 32'hB0);
    issue(1'b0, 32'h204, 4'h0, 32'h0, 1'b0, 32'hB1);
    stb = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_ack", 32'(ack_b), 32'd1);
    chk("pre_rst_stall", 32'(stall_b), 32'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("in_rst_ack", 32'(ack_b), 32'd0);
    chk("in_rst_err", 32'(err_b), 32'd0);
    chk("in_rst_stall", 32'(stall_b), 32'd0);
    chk("in_rst_dat", dat_b, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_cnt", 32'(dut_b.out_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
